mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
//  Multicycle main control FSM for the MIPS core. It decodes op and func, then drives
//  the datapath strobes and the 4-bit ALU_Operation code into the ALU. It also uses the
//  ALU Zero flag to resolve branches.
//  It sits between the instruction register and the shared datapath (ALU, regfile, memory).
// PARAMETERS
//  RESET_STATE  4'd0  state entered on reset (S_FETCH)
// PORTS
//  clk            in   1   system clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  op             in   6   IR[31:26]
//  func           in   6   IR[5:0]
//  Zero           in   1   ALU zero flag (combinational, same cycle as ALU_Operation)
//  mem_ready      in   1   memory completes current access this cycle
//  ALU_Operation  out  4   ALU op code (encoding below)
//  alu_src_a      out  2   0 PC, 1 rs, 2 zero-extended shamt
//  alu_src_b      out  3   0 rt, 1 const 4, 2 sext imm, 3 zext imm, 4 sext imm<<2
//  pc_src         out  2   0 ALU result, 1 ALUOut reg, 2 jump target, 3 rs
//  pc_write       out  1   PC load strobe
//  ir_write       out  1   IR load strobe
//  iord           out  1   0 memory address=PC, 1 address=ALUOut
//  mem_read       out  1   memory read request (held until mem_ready)
//  mem_write      out  1   memory write request (held until mem_ready)
//  reg_write      out  1   regfile write strobe
//  reg_dst        out  1   0 rt, 1 rd
//  mem_to_reg     out  1   0 ALUOut, 1 MDR
//  illegal        out  1   one-cycle pulse on unsupported op/func
//  state_o        out  4   current state (debug)
// BEHAVIOUR
//  - ALU code: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110,
//    sll 0011, srl 0111, sra 1111.
//  - Reset: state=S_FETCH; all strobes 0; illegal 0; ALU_Operation 0000.
//  - Outputs are a Moore decode of state plus the latched op/func; pc_write in
//    S_BRANCH also depends on Zero.
//  - S_FETCH: iord=0, mem_read=1, src_a=0, src_b=1, add, pc_src=0.
//    Stays in S_FETCH while !mem_ready. When mem_ready: ir_write=1, pc_write=1 (PC+4),
//    then go to S_DECODE.
//  - S_DECODE: src_a=0, src_b=4, add (branch target into ALUOut). Next state:
//    R with func in {add,sub,and,or,xor,sll,srl,sra} -> S_EXEC_R; R/jr -> S_JR;
//    addi/andi/ori/xori/lui -> S_EXEC_I; lw/sw -> S_ADDR;
//    beq/bne -> S_BRANCH; j -> S_JUMP; anything else -> S_FETCH with illegal=1.
//  - S_EXEC_R: src_a=1 (2 for shifts), src_b=0, ALU code from func -> S_WB_ALU.
//  - S_EXEC_I: src_a=1; src_b=2 for addi, 3 for andi/ori/xori/lui; code from op -> S_WB_ALU.
//  - S_WB_ALU: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type, 0 otherwise -> S_FETCH.
//  - S_ADDR: src_a=1, src_b=2, add. Next: lw -> S_MEM_RD, sw -> S_MEM_WR.
//  - S_MEM_RD: iord=1, mem_read=1; wait for mem_ready -> S_WB_MEM.
//  - S_MEM_WR: iord=1, mem_write=1; wait for mem_ready -> S_FETCH.
//  - S_WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0 -> S_FETCH.
//  - S_BRANCH: src_a=1, src_b=0, sub, pc_src=1.
//    pc_write = beq ? Zero : ~Zero -> S_FETCH.
//  - S_JUMP: pc_src=2, pc_write=1 -> S_FETCH. S_JR: pc_src=3, pc_write=1 -> S_FETCH.
//  - Latency in cycles, excluding memory waits: R/I=4, lw=5, sw=4, branch=3, j/jr=3.
//  - Request hold: mem_read/mem_write stay asserted and stable until mem_ready.
//    mem_ready outside S_FETCH/S_MEM_RD/S_MEM_WR is ignored.
//  - Reset mid-access drops all requests immediately (asynchronous) and restarts at S_FETCH.
//  - Unreachable state encodings -> S_FETCH.
// STRUCTURE
//  - Package mips_pkg holds opcode, func, ALU code, state and mux-select localparams.
//  - One sub-module, mips_alu_decode: combinational op/func -> ALU_Operation and legal flag.
// TESTING
//  - Reset held mid-S_MEM_RD -> all strobes 0 same cycle; S_FETCH after release.
//  - add (op 0, func 0x20), mem_ready=1 -> ALU_Operation 0000 in EXEC;
//    reg_write and reg_dst=1 in cycle 4.
//  - sra (func 0x03) -> src_a=2, ALU_Operation 1111.
//  - ori (op 0x0D) -> src_b=3, ALU_Operation 0101, reg_dst=0.
//  - lw with mem_ready low for 3 cycles in S_MEM_RD -> mem_read and iord=1 held 4 cycles;
//    total 8 cycles.
//  - beq with Zero=1 -> pc_write=1, pc_src=1; bne with Zero=1 -> pc_write=0.
//  - op 0x3F -> illegal pulses 1 cycle in S_DECODE, back to S_FETCH, no reg_write.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, function codes,
// ALU operation codes, FSM state codes and datapath mux selects.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_WB_ALU = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEM_RD = 4'd6;
  localparam logic [3:0] S_MEM_WR = 4'd7;
  localparam logic [3:0] S_WB_MEM = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_JR     = 4'd11;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS    = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;

  localparam logic [2:0] SRC_B_RT     = 3'd0;
  localparam logic [2:0] SRC_B_FOUR   = 3'd1;
  localparam logic [2:0] SRC_B_SEXT   = 3'd2;
  localparam logic [2:0] SRC_B_ZEXT   = 3'd3;
  localparam logic [2:0] SRC_B_BRANCH = 3'd4;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  function automatic logic is_shift(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational instruction decode: maps op/func to the ALU operation code and
// flags whether the instruction is one the core supports.
import mips_pkg::*;

module mips_alu_decode (
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [3:0] alu_op,
  output logic       legal
);

  // ALU code and legality per opcode; R-type resolves through func
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  begin alu_op = ALU_ADD; legal = 1'b1; end
          FN_SUB:  begin alu_op = ALU_SUB; legal = 1'b1; end
          FN_AND:  begin alu_op = ALU_AND; legal = 1'b1; end
          FN_OR:   begin alu_op = ALU_OR;  legal = 1'b1; end
          FN_XOR:  begin alu_op = ALU_XOR; legal = 1'b1; end
          FN_SLL:  begin alu_op = ALU_SLL; legal = 1'b1; end
          FN_SRL:  begin alu_op = ALU_SRL; legal = 1'b1; end
          FN_SRA:  begin alu_op = ALU_SRA; legal = 1'b1; end
          FN_JR:   begin alu_op = ALU_ADD; legal = 1'b1; end
          default: begin alu_op = ALU_ADD; legal = 1'b0; end
        endcase
      end
      OP_ADDI:        begin alu_op = ALU_ADD; legal = 1'b1; end
      OP_ANDI:        begin alu_op = ALU_AND; legal = 1'b1; end
      OP_ORI:         begin alu_op = ALU_OR;  legal = 1'b1; end
      OP_XORI:        begin alu_op = ALU_XOR; legal = 1'b1; end
      OP_LUI:         begin alu_op = ALU_LUI; legal = 1'b1; end
      OP_LW, OP_SW:   begin alu_op = ALU_ADD; legal = 1'b1; end
      OP_BEQ, OP_BNE: begin alu_op = ALU_SUB; legal = 1'b1; end
      OP_J:           begin alu_op = ALU_ADD; legal = 1'b1; end
      default:        begin alu_op = ALU_ADD; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath strobes as a Moore decode of state and the latched op/func.
import mips_pkg::*;

module mips_mc_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [3:0] ALU_Operation,
  output logic [1:0] alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal,
  output logic [3:0] state_o
);

  logic [3:0] state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] func_q, func_d;
  logic [5:0] dec_op_s;
  logic [5:0] dec_func_s;
  logic [3:0] dec_alu_s;
  logic       dec_legal_s;

  // The IR becomes valid in DECODE, so decode live fields there and the latched copy after
  assign dec_op_s   = (state_q == S_DECODE) ? op   : op_q;
  assign dec_func_s = (state_q == S_DECODE) ? func : func_q;

  mips_alu_decode u_dec (
    .op     (dec_op_s),
    .func   (dec_func_s),
    .alu_op (dec_alu_s),
    .legal  (dec_legal_s)
  );

  assign state_o = state_q;

  // Next-state and op/func capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    func_d  = func_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        op_d   = op;
        func_d = func;
        if (!dec_legal_s) begin
          state_d = S_FETCH;
        end else begin
          case (op)
            OP_RTYPE:                                   state_d = (func == FN_JR) ? S_JR : S_EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:  state_d = S_EXEC_I;
            OP_LW, OP_SW:                               state_d = S_ADDR;
            OP_BEQ, OP_BNE:                             state_d = S_BRANCH;
            OP_J:                                       state_d = S_JUMP;
            default:                                    state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR: begin
        if (op_q == OP_LW) state_d = S_MEM_RD;
        else               state_d = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready) state_d = S_WB_MEM;
        else           state_d = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEM_WR;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode; reset forces every strobe low without waiting for a clock
  always_comb begin
    ALU_Operation = ALU_ADD;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RT;
    pc_src        = PC_SRC_ALU;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    if (rst) begin
      ALU_Operation = ALU_ADD;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRC_B_BRANCH;
          illegal   = ~dec_legal_s;
        end
        S_EXEC_R: begin
          alu_src_a     = is_shift(func_q) ? SRC_A_SHAMT : SRC_A_RS;
          alu_src_b     = SRC_B_RT;
          ALU_Operation = dec_alu_s;
        end
        S_EXEC_I: begin
          alu_src_a     = SRC_A_RS;
          alu_src_b     = (op_q == OP_ADDI) ? SRC_B_SEXT : SRC_B_ZEXT;
          ALU_Operation = dec_alu_s;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          reg_dst   = (op_q == OP_RTYPE);
        end
        S_ADDR: begin
          alu_src_a = SRC_A_RS;
          alu_src_b = SRC_B_SEXT;
        end
        S_MEM_RD: begin
          iord     = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = SRC_A_RS;
          ALU_Operation = ALU_SUB;
          pc_src        = PC_SRC_ALUOUT;
          pc_write      = (op_q == OP_BEQ) ? Zero : ~Zero;
        end
        S_JUMP: begin
          pc_src   = PC_SRC_JUMP;
          pc_write = 1'b1;
        end
        S_JR: begin
          pc_src   = PC_SRC_RS;
          pc_write = 1'b1;
        end
        default: begin
          pc_write = 1'b0;
        end
      endcase
    end
  end

  // State and latched instruction fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      op_q    <= 6'h00;
      func_q  <= 6'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench: a per-instruction reference model expands each instruction
// into expected per-cycle control words, which are compared against the DUT.
module tb_mips_mc_control;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] func;
  logic       Zero;
  logic       mem_ready;
  logic [3:0] ALU_Operation;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_write, ir_write, iord, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] state_o;

  mips_mc_control #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .Zero(Zero), .mem_ready(mem_ready),
    .ALU_Operation(ALU_Operation), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {alu[19:16], src_a[15:14], src_b[13:11], pc_src[10:9],
  //  pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal}
  localparam logic [19:0] C_ALU  = 20'hF0000;
  localparam logic [19:0] C_SA   = 20'h0C000;
  localparam logic [19:0] C_SB   = 20'h03800;
  localparam logic [19:0] C_PS   = 20'h00600;
  localparam logic [19:0] C_IORD = 20'h00040;
  localparam logic [19:0] C_RD   = 20'h00004;
  localparam logic [19:0] C_M2R  = 20'h00002;
  localparam logic [19:0] C_STB  = 20'h001B9;

  typedef struct {
    logic [19:0] exp;
    logic [19:0] care;
    logic        mr;
    logic        z;
    bit          fetch;
  } step_t;

  step_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int rd_cycles;
  logic [19:0] obs;

  assign obs = {ALU_Operation, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord,
                mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal};

  function automatic logic [19:0] pk(input logic [3:0] a, input logic [1:0] sa,
                                     input logic [2:0] sb, input logic [1:0] ps,
                                     input logic [8:0] f);
    return {a, sa, sb, ps, f};
  endfunction

  // ALU code of an ALU-type R instruction, -1 if func is not one
  function automatic int r_code(input logic [5:0] f);
    case (f)
      6'h20: return 0;  6'h22: return 4;  6'h24: return 1;
      6'h25: return 5;  6'h26: return 2;  6'h00: return 3;
      6'h02: return 7;  6'h03: return 15;
      default: return -1;
    endcase
  endfunction

  // ALU code of an immediate ALU instruction, -1 otherwise
  function automatic int i_code(input logic [5:0] o);
    case (o)
      6'h08: return 0;  6'h0C: return 1;  6'h0D: return 5;
      6'h0E: return 2;  6'h0F: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [19:0] e, input logic [19:0] c,
                               input logic mr, input logic z, input bit f);
    step_t s;
    s.exp = e; s.care = c; s.mr = mr; s.z = z; s.fetch = f;
    q.push_back(s);
  endfunction

  // Expand one instruction into expected cycles; zsel<0 means random Zero in the branch cycle
  task automatic build(input logic [5:0] o, input logic [5:0] f, input int fw,
                       input int mw, input int zsel);
    int rc, ic;
    bit legal, shift;
    logic z, pcw;
    rc = r_code(f);
    ic = i_code(o);
    shift = (f == 6'h00) || (f == 6'h02) || (f == 6'h03);
    for (int i = 0; i < fw; i++)
      push(pk(4'd0, 2'd0, 3'd1, 2'd0, 9'b000100000), C_STB | C_ALU | C_SA | C_SB | C_IORD, 1'b0, rbit(), 1'b1);
    push(pk(4'd0, 2'd0, 3'd1, 2'd0, 9'b110100000), C_STB | C_ALU | C_SA | C_SB | C_IORD | C_PS, 1'b1, rbit(), 1'b1);
    legal = (o == 6'h00 && (rc >= 0 || f == 6'h08)) || ic >= 0 || o == 6'h02 || o == 6'h04 ||
            o == 6'h05 || o == 6'h23 || o == 6'h2B;
    push(pk(4'd0, 2'd0, 3'd4, 2'd0, {8'd0, ~legal}), C_STB | C_ALU | C_SA | C_SB, rbit(), rbit(), 1'b0);
    if (legal) begin
      if (o == 6'h00 && f == 6'h08) begin
        push(pk(4'd0, 2'd0, 3'd0, 2'd3, 9'b100000000), C_STB | C_PS, rbit(), rbit(), 1'b0);
      end else if (o == 6'h00) begin
        push(pk(4'(rc), shift ? 2'd2 : 2'd1, 3'd0, 2'd0, 9'd0), C_STB | C_ALU | C_SA | C_SB, rbit(), rbit(), 1'b0);
        push(pk(4'd0, 2'd0, 3'd0, 2'd0, 9'b000001100), C_STB | C_RD | C_M2R, rbit(), rbit(), 1'b0);
      end else if (ic >= 0) begin
        push(pk(4'(ic), 2'd1, (o == 6'h08) ? 3'd2 : 3'd3, 2'd0, 9'd0), C_STB | C_ALU | C_SA | C_SB, rbit(), rbit(), 1'b0);
        push(pk(4'd0, 2'd0, 3'd0, 2'd0, 9'b000001000), C_STB | C_RD | C_M2R, rbit(), rbit(), 1'b0);
      end else if (o == 6'h23 || o == 6'h2B) begin
        push(pk(4'd0, 2'd1, 3'd2, 2'd0, 9'd0), C_STB | C_ALU | C_SA | C_SB, rbit(), rbit(), 1'b0);
        for (int i = 0; i <= mw; i++)
          push(pk(4'd0, 2'd0, 3'd0, 2'd0, (o == 6'h23) ? 9'b001100000 : 9'b001010000),
               C_STB | C_IORD, (i == mw), rbit(), 1'b0);
        if (o == 6'h23)
          push(pk(4'd0, 2'd0, 3'd0, 2'd0, 9'b000001010), C_STB | C_RD | C_M2R, rbit(), rbit(), 1'b0);
      end else if (o == 6'h04 || o == 6'h05) begin
        z = (zsel < 0) ? rbit() : 1'(zsel);
        pcw = (o == 6'h04) ? z : ~z;
        push(pk(4'b0100, 2'd1, 3'd0, 2'd1, {pcw, 8'd0}), C_STB | C_ALU | C_SA | C_SB | C_PS, rbit(), z, 1'b0);
      end else begin
        push(pk(4'd0, 2'd0, 3'd0, 2'd2, 9'b100000000), C_STB | C_PS, rbit(), rbit(), 1'b0);
      end
    end
  endtask

  // Drive up to limit queued cycles (all if limit<0), checking each one; starts and ends at negedge
  task automatic run_q(input string name, input int limit, input bit tail);
    int i;
    step_t s;
    i = 0;
    rd_cycles = 0;
    while (q.size() > 0 && (limit < 0 || i < limit)) begin
      s = q.pop_front();
      mem_ready = s.mr;
      Zero      = s.z;
      #1;
      n_checks++;
      if ((obs & s.care) !== (s.exp & s.care)) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h (care %h)", name, i, obs & s.care, s.exp & s.care, s.care);
      end
      if (s.fetch) begin
        n_checks++;
        if (state_o !== 4'd0) begin
          n_fail++;
          $display("FAIL %s fetch_state cycle %0d: got %0d expected 0", name, i, state_o);
        end
      end
      if (iord && mem_read) rd_cycles++;
      @(posedge clk);
      @(negedge clk);
      i++;
    end
    q.delete();
    if (tail) begin
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (state_o !== 4'd0 || mem_read !== 1'b1 || iord !== 1'b0 || reg_write !== 1'b0) begin
        n_fail++;
        $display("FAIL %s back_to_fetch: got state %0d rd %b iord %b rw %b expected 0 1 0 0",
                 name, state_o, mem_read, iord, reg_write);
      end
      @(negedge clk);
    end
  endtask

  task automatic do_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                          input int fw, input int mw, input int zsel);
    op = o;
    func = f;
    build(o, f, fw, mw, zsel);
    run_q(name, -1, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 6'h00; func = 6'h20; Zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (state_o !== 4'd0 || (obs & (C_STB | C_ALU)) !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_state: got state %0d word %h expected 0 and 00000", state_o, obs & (C_STB | C_ALU));
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    op = 6'h23; func = 6'h00;
    build(6'h23, 6'h00, 0, 5, -1);
    run_q("rst_mid_lw", 4, 1'b0);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_read !== 1'b1 || iord !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got rd %b iord %b expected 1 1", mem_read, iord);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ((obs & C_STB) !== 20'd0 || state_o !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: got strobes %h state %0d expected 0 0", obs & C_STB, state_o);
    end
    @(negedge clk);
    rst = 1'b0;
    do_instr("rst_mid_after_add", 6'h00, 6'h20, 0, 0, -1);
  endtask

  task automatic test_lw_wait();
    op = 6'h23; func = 6'h11;
    build(6'h23, 6'h11, 0, 3, -1);
    run_q("lw_wait", -1, 1'b1);
    n_checks++;
    if (rd_cycles !== 4) begin
      n_fail++;
      $display("FAIL lw_wait_hold: got %0d mem_read/iord cycles expected 4", rd_cycles);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [11];
    logic [5:0] fns [10];
    logic [5:0] o, f;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08, 6'h21};
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) o = 6'($urandom);
      else                           o = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) == 0) f = 6'($urandom);
      else                           f = fns[$urandom_range(0, 9)];
      do_instr("random", o, f, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    test_reset();
    do_instr("add", 6'h00, 6'h20, 0, 0, -1);
    do_instr("add_fetch_wait", 6'h00, 6'h20, 2, 0, -1);
    do_instr("sra", 6'h00, 6'h03, 0, 0, -1);
    do_instr("ori", 6'h0D, 6'h15, 0, 0, -1);
    do_instr("lui", 6'h0F, 6'h00, 0, 0, -1);
    test_lw_wait();
    do_instr("sw", 6'h2B, 6'h00, 1, 2, -1);
    do_instr("beq_z1", 6'h04, 6'h00, 0, 0, 1);
    do_instr("beq_z0", 6'h04, 6'h00, 0, 0, 0);
    do_instr("bne_z1", 6'h05, 6'h00, 0, 0, 1);
    do_instr("bne_z0", 6'h05, 6'h00, 0, 0, 0);
    do_instr("j", 6'h02, 6'h00, 0, 0, -1);
    do_instr("jr", 6'h00, 6'h08, 0, 0, -1);
    do_instr("illegal_op", 6'h3F, 6'h20, 0, 0, -1);
    do_instr("illegal_func", 6'h00, 6'h01, 0, 0, -1);
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
